// File: rtl/branch_resolver_if.sv
// Bus between the program counter and the branch resolver: fetched instruction,
// operands, and the resolved decision, link write and statistics.
`default_nettype none

interface branch_resolver_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic [31:0]      IP;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic             b_taken;
  logic [31:0]      up_amt;
  logic             link_we;
  logic [4:0]       link_rd;
  logic [31:0]      link_data;
  logic             busy;
  logic             misalign;
  logic             illegal;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output instr, IP, rs1_data, rs2_data,
    input  b_taken, up_amt, link_we, link_rd, link_data,
    input  busy, misalign, illegal, br_count, taken_count
  );

  modport slave (
    input  instr, IP, rs1_data, rs2_data,
    output b_taken, up_amt, link_we, link_rd, link_data,
    output busy, misalign, illegal, br_count, taken_count
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver: two-cycle branch/jump decision, PC offset, link write-back
// and control-flow statistics for the program counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_resolver #(
  parameter int CNT_W = 32
) (
  input wire logic           CLK,
  input wire logic           RESET,
  branch_resolver_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RESOLVE = 1'b1
  } state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t           state_q, state_d;
  logic             b_taken_q, b_taken_d;
  logic [31:0]      up_amt_q, up_amt_d;
  logic             link_we_q, link_we_d;
  logic [4:0]       link_rd_q, link_rd_d;
  logic [31:0]      link_data_q, link_data_d;
  logic             misalign_q, misalign_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        is_branch, is_jal, is_jalr, is_cf;
  logic [31:0] imm_b, imm_j, imm_i;
  logic [31:0] jalr_target, target, offset;
  logic        br_cond, bad_f3, taken;

  assign opcode    = bus.instr[6:0];
  assign funct3    = bus.instr[14:12];
  assign rd        = bus.instr[11:7];
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_cf     = is_branch | is_jal | is_jalr;

  assign imm_b = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign imm_j = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
  assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};

  always_comb begin
    br_cond = 1'b0;
    bad_f3  = 1'b0;
    case (funct3)
      3'b000:  br_cond = (bus.rs1_data == bus.rs2_data);
      3'b001:  br_cond = (bus.rs1_data != bus.rs2_data);
      3'b100:  br_cond = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
      3'b101:  br_cond = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
      3'b110:  br_cond = (bus.rs1_data <  bus.rs2_data);
      3'b111:  br_cond = (bus.rs1_data >= bus.rs2_data);
      default: bad_f3  = 1'b1;
    endcase
  end

  // JALR offset is expressed relative to IP so the PC can always add up_amt.
  assign jalr_target = (bus.rs1_data + imm_i) & ~32'd1;
  assign taken       = (is_branch & br_cond) | is_jal | is_jalr;
  assign offset      = is_jalr ? (jalr_target - bus.IP) : (is_jal ? imm_j : imm_b);
  assign target      = is_jalr ? jalr_target : (bus.IP + offset);

  always_comb begin
    state_d       = state_q;
    b_taken_d     = b_taken_q;
    up_amt_d      = up_amt_q;
    link_we_d     = link_we_q;
    link_rd_d     = link_rd_q;
    link_data_d   = link_data_q;
    misalign_d    = misalign_q;
    illegal_d     = illegal_q;
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    case (state_q)
      IDLE: begin
        b_taken_d  = 1'b0;
        up_amt_d   = 32'd0;
        link_we_d  = 1'b0;
        misalign_d = 1'b0;
        illegal_d  = 1'b0;
        if (is_cf) begin
          state_d     = RESOLVE;
          b_taken_d   = taken;
          up_amt_d    = taken ? offset : 32'd0;
          link_we_d   = (is_jal | is_jalr) & (rd != 5'd0);
          link_rd_d   = rd;
          link_data_d = bus.IP + 32'd4;
          misalign_d  = taken & target[1];
          illegal_d   = is_branch & bad_f3;
          br_count_d  = br_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (taken) begin
            taken_count_d = taken_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      RESOLVE: begin
        // The PC re-presents the same instruction here; it must not resolve twice.
        state_d    = IDLE;
        b_taken_d  = 1'b0;
        up_amt_d   = 32'd0;
        link_we_d  = 1'b0;
        misalign_d = 1'b0;
        illegal_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      b_taken_q     <= 1'b0;
      up_amt_q      <= 32'd0;
      link_we_q     <= 1'b0;
      link_rd_q     <= 5'd0;
      link_data_q   <= 32'd0;
      misalign_q    <= 1'b0;
      illegal_q     <= 1'b0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      b_taken_q     <= b_taken_d;
      up_amt_q      <= up_amt_d;
      link_we_q     <= link_we_d;
      link_rd_q     <= link_rd_d;
      link_data_q   <= link_data_d;
      misalign_q    <= misalign_d;
      illegal_q     <= illegal_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign bus.b_taken     = b_taken_q;
  assign bus.up_amt      = up_amt_q;
  assign bus.link_we     = link_we_q;
  assign bus.link_rd     = link_rd_q;
  assign bus.link_data   = link_data_q;
  assign bus.busy        = (state_q == RESOLVE);
  assign bus.misalign    = misalign_q;
  assign bus.illegal     = illegal_q;
  assign bus.br_count    = br_count_q;
  assign bus.taken_count = taken_count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-encoded instructions, expected values
// worked out by hand from the instruction semantics.
`default_nettype none

module tb_branch_resolver;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  branch_resolver_if #(.CNT_W(32)) bus ();

  branch_resolver #(.CNT_W(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc_b(input logic [12:0] m, input logic [2:0] f3);
    return {m[12], m[10:5], 5'd2, 5'd1, f3, m[4:1], m[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] m, input logic [4:0] rd);
    return {m[20], m[10:1], m[11], m[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] m, input logic [4:0] rd);
    return {m, 5'd1, 3'b000, rd, 7'b1100111};
  endfunction

  // Drive a decode cycle, then land 1 time unit after the resolving edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] ip,
                       input logic [31:0] a, input logic [31:0] b);
    bus.instr    = ins;
    bus.IP       = ip;
    bus.rs1_data = a;
    bus.rs2_data = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.instr    = 32'h0000_0013;
    bus.IP       = 32'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    step();
    step();
    RESET = 1'b0;
    check("rst_b_taken", {31'd0, bus.b_taken}, 32'd0);
    check("rst_up_amt", bus.up_amt, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_br_count", bus.br_count, 32'd0);
    check("rst_taken_count", bus.taken_count, 32'd0);

    // Non-control-flow opcode stays idle
    issue(32'h0000_0013, 32'h80, 32'd0, 32'd0);
    check("nop_busy", {31'd0, bus.busy}, 32'd0);
    check("nop_br_count", bus.br_count, 32'd0);

    // BEQ taken, +16
    issue(enc_b(13'd16, 3'b000), 32'h100, 32'd5, 32'd5);
    check("beq_b_taken", {31'd0, bus.b_taken}, 32'd1);
    check("beq_up_amt", bus.up_amt, 32'h10);
    check("beq_busy", {31'd0, bus.busy}, 32'd1);
    check("beq_misalign", {31'd0, bus.misalign}, 32'd0);
    check("beq_link_we", {31'd0, bus.link_we}, 32'd0);
    step();
    check("beq_post_b_taken", {31'd0, bus.b_taken}, 32'd0);
    check("beq_post_up_amt", bus.up_amt, 32'd0);
    check("beq_post_busy", {31'd0, bus.busy}, 32'd0);
    check("beq_br_count", bus.br_count, 32'd1);
    check("beq_taken_count", bus.taken_count, 32'd1);

    // BLT signed: -1 < 1 taken
    issue(enc_b(13'd16, 3'b100), 32'h100, 32'hFFFF_FFFF, 32'd1);
    check("blt_b_taken", {31'd0, bus.b_taken}, 32'd1);
    check("blt_up_amt", bus.up_amt, 32'h10);
    step();
    // BLTU: 0xFFFFFFFF < 1 false
    issue(enc_b(13'd16, 3'b110), 32'h100, 32'hFFFF_FFFF, 32'd1);
    check("bltu_b_taken", {31'd0, bus.b_taken}, 32'd0);
    check("bltu_up_amt", bus.up_amt, 32'd0);
    check("bltu_busy", {31'd0, bus.busy}, 32'd1);
    step();
    check("bltu_br_count", bus.br_count, 32'd3);
    check("bltu_taken_count", bus.taken_count, 32'd2);

    // JAL -8, rd=1
    issue(enc_j(21'h1F_FFF8, 5'd1), 32'h200, 32'd0, 32'd0);
    check("jal_b_taken", {31'd0, bus.b_taken}, 32'd1);
    check("jal_up_amt", bus.up_amt, 32'hFFFF_FFF8);
    check("jal_link_we", {31'd0, bus.link_we}, 32'd1);
    check("jal_link_rd", {27'd0, bus.link_rd}, 32'd1);
    check("jal_link_data", bus.link_data, 32'h204);
    step();
    check("jal_post_link_we", {31'd0, bus.link_we}, 32'd0);
    // JAL rd=0: no link write
    issue(enc_j(21'h1F_FFF8, 5'd0), 32'h200, 32'd0, 32'd0);
    check("jal0_b_taken", {31'd0, bus.b_taken}, 32'd1);
    check("jal0_link_we", {31'd0, bus.link_we}, 32'd0);
    step();
    check("jal0_br_count", bus.br_count, 32'd5);
    check("jal0_taken_count", bus.taken_count, 32'd4);

    // JALR: 0x1003 + 0 -> 0x1002, offset 0xFC2 from 0x40, bit1 set
    issue(enc_i(12'd0, 5'd1), 32'h40, 32'h1003, 32'd0);
    check("jalr_b_taken", {31'd0, bus.b_taken}, 32'd1);
    check("jalr_up_amt", bus.up_amt, 32'hFC2);
    check("jalr_misalign", {31'd0, bus.misalign}, 32'd1);
    check("jalr_link_data", bus.link_data, 32'h44);
    step();
    check("jalr_post_misalign", {31'd0, bus.misalign}, 32'd0);

    // Illegal funct3 010
    issue(enc_b(13'd16, 3'b010), 32'h100, 32'd5, 32'd5);
    check("ill_illegal", {31'd0, bus.illegal}, 32'd1);
    check("ill_b_taken", {31'd0, bus.b_taken}, 32'd0);
    check("ill_up_amt", bus.up_amt, 32'd0);
    step();
    check("ill_post_illegal", {31'd0, bus.illegal}, 32'd0);
    check("ill_br_count", bus.br_count, 32'd7);
    check("ill_taken_count", bus.taken_count, 32'd5);

    // BNE held across four edges: resolve, idle, resolve, idle
    issue(enc_b(13'd8, 3'b001), 32'h300, 32'd1, 32'd2);
    check("b2b_busy0", {31'd0, bus.busy}, 32'd1);
    check("b2b_up_amt0", bus.up_amt, 32'h8);
    step();
    check("b2b_busy1", {31'd0, bus.busy}, 32'd0);
    check("b2b_b_taken1", {31'd0, bus.b_taken}, 32'd0);
    step();
    check("b2b_busy2", {31'd0, bus.busy}, 32'd1);
    check("b2b_b_taken2", {31'd0, bus.b_taken}, 32'd1);
    bus.instr = 32'h0000_0013;
    step();
    check("b2b_busy3", {31'd0, bus.busy}, 32'd0);
    check("b2b_br_count", bus.br_count, 32'd9);
    check("b2b_taken_count", bus.taken_count, 32'd7);

    // Asynchronous reset during RESOLVE
    issue(enc_j(21'd16, 5'd3), 32'h500, 32'd0, 32'd0);
    check("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
    RESET = 1'b1;
    #1;
    check("mid_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_b_taken", {31'd0, bus.b_taken}, 32'd0);
    check("mid_up_amt", bus.up_amt, 32'd0);
    check("mid_link_we", {31'd0, bus.link_we}, 32'd0);
    check("mid_br_count", bus.br_count, 32'd0);
    check("mid_taken_count", bus.taken_count, 32'd0);
    bus.instr = 32'h0000_0013;
    step();
    RESET = 1'b0;
    issue(enc_b(13'd8, 3'b001), 32'h600, 32'd7, 32'd9);
    check("post_rst_b_taken", {31'd0, bus.b_taken}, 32'd1);
    check("post_rst_up_amt", bus.up_amt, 32'h8);
    bus.instr = 32'h0000_0013;
    step();
    check("post_rst_br_count", bus.br_count, 32'd1);
    check("post_rst_taken_count", bus.taken_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Companion to the program counter. Supplies the branch/jump decision (`b_taken`) and the PC-relative offset (`up_amt`) that the PC consumes.
- Follows the PC's two-cycle control-flow protocol:
  - Decode cycle: PC sees a control-flow opcode and holds IP.
  - Resolve cycle: PC applies `IP + up_amt` if taken, else `IP + 4`.
- Also produces the JAL/JALR link write-back and keeps branch statistics counters.

Parameters:
- CNT_W, 32, width of the statistics counters (wrap modulo 2^CNT_W).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- instr  input  32  instruction currently fetched at IP.
- IP  input  32  current PC value, the address of `instr`.
- rs1_data  input  32  register-file read of `instr[19:15]`.
- rs2_data  input  32  register-file read of `instr[24:20]`.
- b_taken  output  1  registered; 1 during RESOLVE when the PC must redirect.
- up_amt  output  32  registered; offset added to IP by the PC; valid during RESOLVE.
- link_we  output  1  registered; 1-cycle pulse in RESOLVE for JAL/JALR with rd≠0.
- link_rd  output  5  registered destination register for the link write.
- link_data  output  32  registered; IP_captured + 4.
- busy  output  1  1 while in RESOLVE.
- misalign  output  1  1-cycle pulse in RESOLVE when a taken target has `target[1] = 1`. Report only; the redirect still happens.
- illegal  output  1  1-cycle pulse in RESOLVE for a branch with funct3 010 or 011.
- br_count  output  CNT_W  number of control-flow instructions resolved.
- taken_count  output  CNT_W  number of those that were taken.

Behaviour:
- Reset (asynchronous): state = IDLE; all outputs and counters = 0.
- Opcode classes on `instr[6:0]`:
  - 1100011 = BRANCH
  - 1101111 = JAL
  - 1100111 = JALR
  - all others are non-control-flow.
- FSM states: IDLE and RESOLVE.
  - IDLE with a control-flow opcode → RESOLVE. On that edge, register `b_taken`, `up_amt`, `link_*`, `misalign`, `illegal`, and update the counters.
  - IDLE with any other opcode → stay in IDLE; `b_taken` = 0 and `up_amt` = 0.
  - RESOLVE → IDLE unconditionally.
    - `instr` is ignored in RESOLVE, because the PC holds IP and the same instruction is re-presented. This guarantees exactly one resolution per instruction.
    - On the RESOLVE→IDLE edge, `b_taken`, `link_we`, `misalign` and `illegal` clear to 0; `up_amt` clears to 0.
- Latency: decision is visible exactly 1 cycle after the decode cycle, i.e. throughout the PC's stall cycle.
- Immediates (sign-extended to 32 bits):
  - B-type: {i[31], i[7], i[30:25], i[11:8], 0}
  - J-type: {i[31], i[19:12], i[20], i[30:21], 0}
  - I-type: i[31:20]
- BRANCH: taken per funct3; on taken, `up_amt` = B-imm. Not-taken or illegal → `b_taken` = 0 and `up_amt` = 0. Illegal branches pulse `illegal`.
  - 000 eq
  - 001 ne
  - 100 signed lt
  - 101 signed ge
  - 110 unsigned lt
  - 111 unsigned ge
  - 010/011 illegal, treated as not taken.
- JAL: `b_taken` = 1; `up_amt` = J-imm.
- JALR:
  - `b_taken` = 1.
  - target = (rs1_data + I-imm) with bit0 forced to 0.
  - `up_amt` = target − IP (mod 2^32), so that the PC's `IP + up_amt` equals target.
- Link outputs: `link_data` = IP + 4 (wraps); `link_rd` = i[11:7].
- Counters:
  - `br_count` increments by 1 per resolution.
  - `taken_count` increments by 1 when taken.
  - Both wrap silently at all-ones.
- Reset asserted during RESOLVE: immediate return to IDLE; outputs zeroed; that instruction is not counted (the counter updates have already been zeroed by the reset).

Test Plan:
- BEQ, IP = 0x100, rs1 = rs2 = 5, B-imm = +16 → next cycle `b_taken` = 1, `up_amt` = 0x10, `busy` = 1; following cycle `b_taken` = 0; `br_count` = 1, `taken_count` = 1.
- BLT, rs1 = 0xFFFFFFFF, rs2 = 1 → taken. BLTU with the same operands → not taken, `up_amt` = 0.
- JAL, IP = 0x200, imm = −8, rd = 1 → `up_amt` = 0xFFFFFFF8, `link_we` pulse, `link_rd` = 1, `link_data` = 0x204. Same with rd = 0 → `link_we` stays 0.
- JALR, IP = 0x40, rs1 = 0x1003, imm = 0 → target 0x1002, `up_amt` = 0xFC2, `misalign` pulse.
- Branch with funct3 = 010 → `illegal` pulse, `b_taken` = 0. Two back-to-back identical control-flow instructions with `instr` held → exactly two resolutions, separated by one IDLE cycle.
- RESET asserted mid-RESOLVE → outputs 0 asynchronously; counters 0; next BNE resolves normally.
